// File: rtl/pisca_pkg.sv
// Shared definitions for the LED blink sequencer: state codes and the
// effective phase-duration helper used for the fast (nivel=1) mode.
package pisca_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'b000,
    LIGADO    = 3'b001,
    DESLIGADO = 3'b010,
    FIM       = 3'b011
  } estado_t;

  // Fast mode halves a phase; a phase can never shrink below one cycle.
  function automatic logic [31:0] duracao_efetiva(input logic [31:0] base_cnt,
                                                  input logic        nivel);
    logic [31:0] dur_s;
    if (nivel) begin
      dur_s = base_cnt >> 1;
      if (dur_s == 32'd0) begin
        dur_s = 32'd1;
      end else begin
        dur_s = dur_s;
      end
    end else begin
      dur_s = base_cnt;
    end
    return dur_s;
  endfunction

endpackage

// File: rtl/sequenciador_pisca_leds_if.sv
// Control-unit <-> blink sequencer signal bundle.
// PISCA_CONTINUO_EN adds the 'continuo' request line.
interface sequenciador_pisca_leds_if;

  logic       iniciar;
  logic       cancelar;
  logic       nivel;
  logic [3:0] leds_in;
`ifdef PISCA_CONTINUO_EN
  logic       continuo;
`endif
  logic [3:0] leds_out;
  logic       ocupado;
  logic       fim;
  logic [2:0] db_estado;

`ifdef PISCA_CONTINUO_EN
  modport master (output iniciar, cancelar, nivel, leds_in, continuo,
                  input  leds_out, ocupado, fim, db_estado);
  modport slave  (input  iniciar, cancelar, nivel, leds_in, continuo,
                  output leds_out, ocupado, fim, db_estado);
`else
  modport master (output iniciar, cancelar, nivel, leds_in,
                  input  leds_out, ocupado, fim, db_estado);
  modport slave  (input  iniciar, cancelar, nivel, leds_in,
                  output leds_out, ocupado, fim, db_estado);
`endif

endinterface

// File: rtl/temporizador_pisca.sv
// Loadable phase down-counter; 'terminal' flags the last cycle of a phase
// (count == 1), so a phase loaded with K lasts exactly K cycles.
module temporizador_pisca #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             carregar,
  input  logic             habilitar,
  input  logic [CNT_W-1:0] valor,
  output logic             terminal
);

  logic [CNT_W-1:0] contagem_r;

  // Phase counter: load wins over decrement; it never wraps below zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_r <= '0;
    end else if (carregar) begin
      contagem_r <= valor;
    end else if (habilitar && (contagem_r != '0)) begin
      contagem_r <= contagem_r - CNT_W'(1);
    end else begin
      contagem_r <= contagem_r;
    end
  end

  assign terminal = (contagem_r == CNT_W'(1));

endmodule

// File: rtl/sequenciador_pisca_leds.sv
// LED blink sequencer: N lit/dark cycles of a latched pattern, then a
// one-cycle done pulse. PISCA_CONTINUO_EN enables endless repeat mode.
module sequenciador_pisca_leds
  import pisca_pkg::*;
#(
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 500,
  parameter int N_PISCADAS = 3,
  parameter int CNT_W      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  sequenciador_pisca_leds_if.slave  ctrl
);

  localparam int                 BLINK_W    = $clog2(N_PISCADAS) + 1;
  localparam logic [BLINK_W-1:0] ULTIMA     = BLINK_W'(N_PISCADAS - 1);
  localparam logic [CNT_W-1:0]   ON_NORMAL  = CNT_W'(duracao_efetiva(32'(ON_CYCLES), 1'b0));
  localparam logic [CNT_W-1:0]   ON_RAPIDO  = CNT_W'(duracao_efetiva(32'(ON_CYCLES), 1'b1));
  localparam logic [CNT_W-1:0]   OFF_NORMAL = CNT_W'(duracao_efetiva(32'(OFF_CYCLES), 1'b0));
  localparam logic [CNT_W-1:0]   OFF_RAPIDO = CNT_W'(duracao_efetiva(32'(OFF_CYCLES), 1'b1));

  estado_t            estado_r, estado_next_s;
  logic [3:0]         padrao_r, padrao_next_s;
  logic               nivel_r, nivel_next_s;
  logic [BLINK_W-1:0] piscada_r, piscada_next_s;
`ifdef PISCA_CONTINUO_EN
  logic               continuo_r, continuo_next_s;
`endif

  logic               timer_carregar_s;
  logic               timer_habilitar_s;
  logic [CNT_W-1:0]   timer_valor_s;
  logic               timer_fim_s;
  logic [CNT_W-1:0]   on_s;
  logic [CNT_W-1:0]   off_s;

  logic [3:0]         leds_r;
  logic               ocupado_r;
  logic               fim_r;
  logic [2:0]         db_estado_r;

  assign on_s  = nivel_r ? ON_RAPIDO  : ON_NORMAL;
  assign off_s = nivel_r ? OFF_RAPIDO : OFF_NORMAL;

  temporizador_pisca #(
    .CNT_W (CNT_W)
  ) u_temporizador (
    .clock     (clock),
    .reset     (reset),
    .carregar  (timer_carregar_s),
    .habilitar (timer_habilitar_s),
    .valor     (timer_valor_s),
    .terminal  (timer_fim_s)
  );

  // State and sequence context registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r   <= OCIOSO;
      padrao_r   <= 4'b0000;
      nivel_r    <= 1'b0;
      piscada_r  <= '0;
`ifdef PISCA_CONTINUO_EN
      continuo_r <= 1'b0;
`endif
    end else begin
      estado_r   <= estado_next_s;
      padrao_r   <= padrao_next_s;
      nivel_r    <= nivel_next_s;
      piscada_r  <= piscada_next_s;
`ifdef PISCA_CONTINUO_EN
      continuo_r <= continuo_next_s;
`endif
    end
  end

  // Next-state logic and timer control; cancelar outranks every transition.
  always_comb begin
    estado_next_s     = estado_r;
    padrao_next_s     = padrao_r;
    nivel_next_s      = nivel_r;
    piscada_next_s    = piscada_r;
`ifdef PISCA_CONTINUO_EN
    continuo_next_s   = continuo_r;
`endif
    timer_carregar_s  = 1'b0;
    timer_habilitar_s = 1'b0;
    timer_valor_s     = '0;
    case (estado_r)
      OCIOSO: begin
        if (ctrl.iniciar && !ctrl.cancelar) begin
          padrao_next_s    = ctrl.leds_in;
          nivel_next_s     = ctrl.nivel;
          piscada_next_s   = '0;
`ifdef PISCA_CONTINUO_EN
          continuo_next_s  = ctrl.continuo;
`endif
          timer_carregar_s = 1'b1;
          timer_valor_s    = ctrl.nivel ? ON_RAPIDO : ON_NORMAL;
          estado_next_s    = LIGADO;
        end else begin
          estado_next_s    = OCIOSO;
        end
      end
      LIGADO: begin
        if (ctrl.cancelar) begin
          estado_next_s = OCIOSO;
        end else if (timer_fim_s) begin
          if (piscada_r == ULTIMA) begin
`ifdef PISCA_CONTINUO_EN
            if (continuo_r) begin
              piscada_next_s   = '0;
              timer_carregar_s = 1'b1;
              timer_valor_s    = off_s;
              estado_next_s    = DESLIGADO;
            end else begin
              estado_next_s    = FIM;
            end
`else
            estado_next_s = FIM;
`endif
          end else begin
            piscada_next_s   = piscada_r + BLINK_W'(1);
            timer_carregar_s = 1'b1;
            timer_valor_s    = off_s;
            estado_next_s    = DESLIGADO;
          end
        end else begin
          timer_habilitar_s = 1'b1;
        end
      end
      DESLIGADO: begin
        if (ctrl.cancelar) begin
          estado_next_s = OCIOSO;
        end else if (timer_fim_s) begin
          timer_carregar_s = 1'b1;
          timer_valor_s    = on_s;
          estado_next_s    = LIGADO;
        end else begin
          timer_habilitar_s = 1'b1;
        end
      end
      FIM: begin
        estado_next_s = OCIOSO;
      end
      default: begin
        estado_next_s = OCIOSO;
      end
    endcase
  end

  // Moore outputs registered from the next state so they track state exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leds_r      <= 4'b0000;
      ocupado_r   <= 1'b0;
      fim_r       <= 1'b0;
      db_estado_r <= 3'b000;
    end else begin
      leds_r      <= (estado_next_s == LIGADO) ? padrao_next_s : 4'b0000;
      ocupado_r   <= (estado_next_s != OCIOSO);
      fim_r       <= (estado_next_s == FIM);
      db_estado_r <= estado_next_s;
    end
  end

  assign ctrl.leds_out  = leds_r;
  assign ctrl.ocupado   = ocupado_r;
  assign ctrl.fim       = fim_r;
  assign ctrl.db_estado = db_estado_r;

endmodule

// File: tb/tb_sequenciador_pisca_leds.sv
// Bench for sequenciador_pisca_leds: two instances (N=2 and N=1) driven with
// the same directed + random stimulus and compared against a cycle-position model.
module tb_sequenciador_pisca_leds;

  localparam int ON_T  = 4;
  localparam int OFF_T = 3;

  logic clock;
  logic reset;

  int testes;
  int falhas;

  // Model state per instance: position within the running sequence (-1 = idle).
  int         pos_m [2];
  int         on_m  [2];
  int         off_m [2];
  logic [3:0] pat_m [2];
  int         n_m   [2];

  sequenciador_pisca_leds_if if_a ();
  sequenciador_pisca_leds_if if_b ();

  sequenciador_pisca_leds #(
    .ON_CYCLES (ON_T), .OFF_CYCLES (OFF_T), .N_PISCADAS (2), .CNT_W (16)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .ctrl  (if_a)
  );

  sequenciador_pisca_leds #(
    .ON_CYCLES (ON_T), .OFF_CYCLES (OFF_T), .N_PISCADAS (1), .CNT_W (16)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .ctrl  (if_b)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    testes++;
    if (obtido !== esperado) begin
      falhas++;
      $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, obtido, esperado);
    end
  endtask

  function automatic int duracao(input int base, input logic niv);
    int d;
    d = niv ? base / 2 : base;
    if (d < 1) d = 1;
    return d;
  endfunction

  function automatic int comprimento(input int d);
    return n_m[d] * on_m[d] + (n_m[d] - 1) * off_m[d] + 1;
  endfunction

  // Expected {leds_out, ocupado, fim, db_estado} at the current position.
  function automatic logic [9:0] esperado(input int d);
    int r;
    if (pos_m[d] < 0) return 10'd0;
    if (pos_m[d] == comprimento(d) - 1) return {4'b0000, 1'b1, 1'b1, 3'd3};
    r = pos_m[d] % (on_m[d] + off_m[d]);
    if (r < on_m[d]) return {pat_m[d], 1'b1, 1'b0, 3'd1};
    return {4'b0000, 1'b1, 1'b0, 3'd2};
  endfunction

  task automatic modelo(input logic ini, input logic canc, input logic niv, input logic [3:0] pat);
    for (int d = 0; d < 2; d++) begin
      if (pos_m[d] >= 0) begin
        if (canc) begin
          pos_m[d] = -1;
        end else begin
          pos_m[d]++;
          if (pos_m[d] == comprimento(d)) pos_m[d] = -1;
        end
      end else if (ini && !canc) begin
        pos_m[d] = 0;
        on_m[d]  = duracao(ON_T, niv);
        off_m[d] = duracao(OFF_T, niv);
        pat_m[d] = pat;
      end
    end
  endtask

  task automatic confere(input string tag_a, input string tag_b);
    verifica(tag_a, 32'({if_a.leds_out, if_a.ocupado, if_a.fim, if_a.db_estado}), 32'(esperado(0)));
    verifica(tag_b, 32'({if_b.leds_out, if_b.ocupado, if_b.fim, if_b.db_estado}), 32'(esperado(1)));
  endtask

  // One clock: drive at negedge, advance model at posedge, check at next negedge.
  task automatic ciclo(input logic ini, input logic canc, input logic niv, input logic [3:0] pat);
    if_a.iniciar = ini;  if_a.cancelar = canc; if_a.nivel = niv; if_a.leds_in = pat;
    if_b.iniciar = ini;  if_b.cancelar = canc; if_b.nivel = niv; if_b.leds_in = pat;
    @(posedge clock);
    modelo(ini, canc, niv, pat);
    @(negedge clock);
    confere("seq_n2", "seq_n1");
  endtask

  task automatic ocioso_aleatorio(input int n);
    for (int i = 0; i < n; i++) begin
      ciclo(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    testes = 0;
    falhas = 0;
    clock  = 1'b0;
    reset  = 1'b0;
    n_m[0] = 2;
    n_m[1] = 1;
    for (int d = 0; d < 2; d++) begin
      pos_m[d] = -1; on_m[d] = ON_T; off_m[d] = OFF_T; pat_m[d] = 4'b0000;
    end
    if_a.iniciar = 1'b0; if_a.cancelar = 1'b0; if_a.nivel = 1'b0; if_a.leds_in = 4'b0000;
    if_b.iniciar = 1'b0; if_b.cancelar = 1'b0; if_b.nivel = 1'b0; if_b.leds_in = 4'b0000;
`ifdef PISCA_CONTINUO_EN
    if_a.continuo = 1'b0;
    if_b.continuo = 1'b0;
`endif

    repeat (2) @(negedge clock);
    confere("reset_n2", "reset_n1");
    reset = 1'b1;

    // Normal speed sequence, with inputs wiggling mid-sequence.
    ciclo(1'b1, 1'b0, 1'b0, 4'b1010);
    ocioso_aleatorio(14);
    // Fast mode.
    ciclo(1'b1, 1'b0, 1'b1, 4'b1010);
    ocioso_aleatorio(8);
    // Cancel on the second dark cycle of dut_a.
    ciclo(1'b1, 1'b0, 1'b0, 4'b1010);
    ocioso_aleatorio(5);
    ciclo(1'b0, 1'b1, 1'b0, 4'b0000);
    ocioso_aleatorio(4);
    // Re-start attempt while busy is ignored.
    ciclo(1'b1, 1'b0, 1'b0, 4'b1010);
    ocioso_aleatorio(2);
    ciclo(1'b1, 1'b0, 1'b1, 4'b0101);
    ocioso_aleatorio(12);
    // Start and cancel together while idle: stays idle.
    ciclo(1'b1, 1'b1, 1'b0, 4'b1111);
    ocioso_aleatorio(3);

    // Asynchronous reset while lit.
    ciclo(1'b1, 1'b0, 1'b0, 4'b1010);
    ocioso_aleatorio(2);
    reset = 1'b0;
    #1;
    verifica("reset_async_n2", 32'({if_a.leds_out, if_a.ocupado, if_a.fim, if_a.db_estado}), 32'd0);
    verifica("reset_async_n1", 32'({if_b.leds_out, if_b.ocupado, if_b.fim, if_b.db_estado}), 32'd0);
    pos_m[0] = -1;
    pos_m[1] = -1;
    @(negedge clock);
    reset = 1'b1;
    ciclo(1'b1, 1'b0, 1'b0, 4'b0110);
    ocioso_aleatorio(13);

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      ciclo(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
